fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters (fixed 2 in this release).
REQ-002 Parameter MAX_OUTST, default 4, maximum in-flight FPU operations (power of 2, >=2).
REQ-003 Parameter OP_W, default 6, width of apu_op.
REQ-004 Parameter FLG_W, default 15, width of apu_flags.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 m_req_i  in  NUM_REQ  per-requester request.
REQ-008 m_gnt_o  out  NUM_REQ  per-requester grant.
REQ-009 m_operands_i  in  NUM_REQ x 3 x 32  per-requester operands.
REQ-010 m_op_i  in  NUM_REQ x OP_W  per-requester opcode.
REQ-011 m_flags_i  in  NUM_REQ x FLG_W  per-requester flags (including rounding mode).
REQ-012 m_rvalid_o  out  NUM_REQ  per-requester response valid.
REQ-013 m_rdata_o  out  32  response data, shared bus to all requesters.
REQ-014 m_rflags_o  out  5  response exception flags, shared bus.
REQ-015 fpu_req_o / fpu_gnt_i  out/in  1/1  FPU request and grant.
REQ-016 fpu_operands_o, fpu_op_o, fpu_flags_o  out  3x32, OP_W, FLG_W  muxed payload to the FPU.
REQ-017 fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i  in  1, 32, 5  FPU response.
REQ-018 outst_cnt_o  out  clog2(MAX_OUTST)+1  current in-flight count.
REQ-019 err_spurious_o  out  1  sticky flag: response received with nothing in flight.

Function
REQ-020 The FPU SHALL be treated as in-order with a latency of 0 or more cycles; latency 0 means fpu_rvalid_i is asserted in the handshake cycle.
REQ-021 Arbitration SHALL be combinational each cycle: round-robin with priority pointer rr; the winner is the first requester with m_req_i=1, searched from rr.
REQ-022 fpu_req_o SHALL equal (any m_req_i) AND NOT full, where full = (count==MAX_OUTST) AND NOT pop_this_cycle.
REQ-023 Payload outputs SHALL mux the winner's inputs; when no requester is active, they SHALL select requester 0.
REQ-024 m_gnt_o[winner] SHALL equal fpu_req_o AND fpu_gnt_i; all other grant bits SHALL be 0; at most one grant bit SHALL be set per cycle.
REQ-025 On a handshake, rr SHALL update to winner+1 (mod NUM_REQ) at the next edge; otherwise rr SHALL hold.
REQ-026 An ID FIFO of depth MAX_OUTST SHALL record the winner index on every handshake that is not consumed in the same cycle.
REQ-027 Response routing id = head of FIFO when count>0; otherwise the winner of the current handshake (zero-latency bypass).
REQ-028 On fpu_rvalid_i with a valid id, m_rvalid_o[id]=1 in the same cycle, and m_rdata_o / m_rflags_o SHALL pass fpu_rdata_i / fpu_rflags_i combinationally.
REQ-029 Pop SHALL occur on fpu_rvalid_i when count>0; push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-030 When count==0, fpu_rvalid_i=1 and there is no handshake: m_rvalid_o SHALL be all 0, err_spurious_o SHALL set at the next edge, and count SHALL stay 0 (no underflow).
REQ-031 FIFO pointers SHALL wrap modulo MAX_OUTST; count SHALL never exceed MAX_OUTST.
REQ-032 When idle, m_rdata_o and m_rflags_o SHALL be 0 (gated by fpu_rvalid_i).

Reset
REQ-033 While rst_i=1 (asynchronous): rr=0, FIFO empty, pointers=0, count=0, err_spurious_o=0, all m_gnt_o and m_rvalid_o forced to 0, fpu_req_o=0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight IDs; responses arriving after reset release with count 0 SHALL follow REQ-030.
REQ-035 Operation SHALL resume on the first rising edge after rst_i falls; no handshake SHALL occur while rst_i=1.

Verification
REQ-036 Both m_req_i held at 1, fpu_gnt_i=1, FPU latency 2 -> grants alternate 0,1,0,1; responses routed 0,1,0,1 with matching rdata.
REQ-037 Latency 0: single request from requester 1 with rdata=0x3F800000 -> m_gnt_o[1] and m_rvalid_o[1] in the same cycle; outst_cnt_o stays 0.
REQ-038 fpu_rvalid_i held at 0, 4 handshakes completed -> outst_cnt_o=4, fpu_req_o=0 and no grant; the cycle fpu_rvalid_i=1 -> a grant is allowed and the count stays 4.
REQ-039 fpu_rvalid_i pulsed with count 0 and no request -> no m_rvalid_o; err_spurious_o=1 from the next cycle until reset.
REQ-040 Assert rst_i with 3 operations in flight -> all outputs reach their reset values immediately (async); after release the count is 0 and rr is 0.
REQ-041 fpu_gnt_i=0 for 5 cycles with requester 0 requesting -> no grant, payload stable on requester 0, rr unchanged.

Source files
------------

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one in-order FPU between NUM_REQ requesters.
// An ID FIFO tracks in-flight operations so responses are routed back to their issuer.
module fpu_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int MAX_OUTST = 4,
   parameter int OP_W      = 6,
   parameter int FLG_W     = 15
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NUM_REQ-1:0]                  m_req_i,
   output logic [NUM_REQ-1:0]                  m_gnt_o,
   input  logic [NUM_REQ-1:0][2:0][31:0]       m_operands_i,
   input  logic [NUM_REQ-1:0][OP_W-1:0]        m_op_i,
   input  logic [NUM_REQ-1:0][FLG_W-1:0]       m_flags_i,
   output logic [NUM_REQ-1:0]                  m_rvalid_o,
   output logic [31:0]                         m_rdata_o,
   output logic [4:0]                          m_rflags_o,
   output logic                                fpu_req_o,
   input  logic                                fpu_gnt_i,
   output logic [2:0][31:0]                    fpu_operands_o,
   output logic [OP_W-1:0]                     fpu_op_o,
   output logic [FLG_W-1:0]                    fpu_flags_o,
   input  logic                                fpu_rvalid_i,
   input  logic [31:0]                         fpu_rdata_i,
   input  logic [4:0]                          fpu_rflags_i,
   output logic [$clog2(MAX_OUTST):0]          outst_cnt_o,
   output logic                                err_spurious_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int CNT_W = $clog2(MAX_OUTST) + 1;

   logic [IDX_W-1:0] rr_q, rr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [IDX_W-1:0] mem_q [MAX_OUTST];
   logic [IDX_W-1:0] mem_d [MAX_OUTST];

   logic [IDX_W-1:0] winner_s;
   logic             any_req_s;
   logic             pop_s, full_s, hs_s, bypass_s, push_s, rsp_ok_s;
   logic [IDX_W-1:0] rsp_id_s;

   // Round-robin search: scan downward so the lowest offset from rr wins; defaults to requester 0.
   always_comb begin
      winner_s  = {IDX_W{1'b0}};
      any_req_s = |m_req_i;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         winner_s = m_req_i[(int'(rr_q) + i) % NUM_REQ]
                    ? IDX_W'((int'(rr_q) + i) % NUM_REQ) : winner_s;
      end
   end

   // Handshake, FIFO control and response routing.
   always_comb begin
      pop_s     = fpu_rvalid_i && (cnt_q != {CNT_W{1'b0}});
      full_s    = (cnt_q == CNT_W'(MAX_OUTST)) && !pop_s;
      fpu_req_o = any_req_s && !full_s && !rst_i;
      hs_s      = fpu_req_o && fpu_gnt_i;
      // Zero-latency response consumes the ID directly, so it never enters the FIFO.
      bypass_s  = fpu_rvalid_i && (cnt_q == {CNT_W{1'b0}}) && hs_s;
      push_s    = hs_s && !bypass_s;
      rsp_id_s  = (cnt_q != {CNT_W{1'b0}}) ? mem_q[rd_ptr_q] : winner_s;
      rsp_ok_s  = (pop_s || bypass_s) && !rst_i;

      m_gnt_o              = {NUM_REQ{1'b0}};
      m_gnt_o[winner_s]    = hs_s;
      m_rvalid_o           = {NUM_REQ{1'b0}};
      m_rvalid_o[rsp_id_s] = rsp_ok_s;

      fpu_operands_o = m_operands_i[winner_s];
      fpu_op_o       = m_op_i[winner_s];
      fpu_flags_o    = m_flags_i[winner_s];
      m_rdata_o      = fpu_rvalid_i ? fpu_rdata_i  : 32'd0;
      m_rflags_o     = fpu_rvalid_i ? fpu_rflags_i : 5'd0;

      outst_cnt_o    = cnt_q;
      err_spurious_o = err_q;
   end

   // Next-state computation for pointer, counter, FIFO and error flag.
   always_comb begin
      rr_d     = hs_s ? IDX_W'((int'(winner_s) + 1) % NUM_REQ) : rr_q;
      wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      cnt_d    = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
      err_d    = err_q || (fpu_rvalid_i && (cnt_q == {CNT_W{1'b0}}) && !hs_s);
      for (int i = 0; i < MAX_OUTST; i++) begin
         mem_d[i] = (push_s && (wr_ptr_q == PTR_W'(i))) ? winner_s : mem_q[i];
      end
   end

   // State registers; reset discards all in-flight IDs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q     <= {IDX_W{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         err_q    <= 1'b0;
         for (int i = 0; i < MAX_OUTST; i++) begin
            mem_q[i] <= {IDX_W{1'b0}};
         end
      end else begin
         rr_q     <= rr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         for (int i = 0; i < MAX_OUTST; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed, table-driven bench for fpu_arbiter plus hand-written reset sequences.
module tb_fpu_arbiter;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic [1:0]             m_req_i;
   logic [1:0]             m_gnt_o;
   logic [1:0][2:0][31:0]  m_operands_i;
   logic [1:0][5:0]        m_op_i;
   logic [1:0][14:0]       m_flags_i;
   logic [1:0]             m_rvalid_o;
   logic [31:0]            m_rdata_o;
   logic [4:0]             m_rflags_o;
   logic                   fpu_req_o;
   logic                   fpu_gnt_i;
   logic [2:0][31:0]       fpu_operands_o;
   logic [5:0]             fpu_op_o;
   logic [14:0]            fpu_flags_o;
   logic                   fpu_rvalid_i;
   logic [31:0]            fpu_rdata_i;
   logic [4:0]             fpu_rflags_i;
   logic [2:0]             outst_cnt_o;
   logic                   err_spurious_o;

   fpu_arbiter dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .m_req_i        (m_req_i),
      .m_gnt_o        (m_gnt_o),
      .m_operands_i   (m_operands_i),
      .m_op_i         (m_op_i),
      .m_flags_i      (m_flags_i),
      .m_rvalid_o     (m_rvalid_o),
      .m_rdata_o      (m_rdata_o),
      .m_rflags_o     (m_rflags_o),
      .fpu_req_o      (fpu_req_o),
      .fpu_gnt_i      (fpu_gnt_i),
      .fpu_operands_o (fpu_operands_o),
      .fpu_op_o       (fpu_op_o),
      .fpu_flags_o    (fpu_flags_o),
      .fpu_rvalid_i   (fpu_rvalid_i),
      .fpu_rdata_i    (fpu_rdata_i),
      .fpu_rflags_i   (fpu_rflags_i),
      .outst_cnt_o    (outst_cnt_o),
      .err_spurious_o (err_spurious_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0]  req;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic [1:0]  e_gnt;
      logic        e_req;
      logic [1:0]  e_rv;
      logic [2:0]  e_cnt;
      logic        e_err;
      logic        e_sel;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [95:0] ops_c   [2];
   logic [5:0]  op_c    [2];
   logic [14:0] flags_c [2];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rdata,
                      input logic [1:0] e_gnt, input logic e_req, input logic [1:0] e_rv,
                      input logic [2:0] e_cnt, input logic e_err, input logic e_sel);
      vec_t v;
      v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
      v.e_gnt = e_gnt; v.e_req = e_req; v.e_rv = e_rv;
      v.e_cnt = e_cnt; v.e_err = e_err; v.e_sel = e_sel;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
      m_req_i      = req;
      fpu_gnt_i    = gnt;
      fpu_rvalid_i = rv;
      fpu_rdata_i  = rdata;
      fpu_rflags_i = rdata[4:0];
   endtask

   initial begin
      ops_c[0]   = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001};
      ops_c[1]   = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001};
      op_c[0]    = 6'h0A;  op_c[1]    = 6'h15;
      flags_c[0] = 15'h1234; flags_c[1] = 15'h4321;
      m_operands_i[0] = ops_c[0]; m_operands_i[1] = ops_c[1];
      m_op_i[0] = op_c[0]; m_op_i[1] = op_c[1];
      m_flags_i[0] = flags_c[0]; m_flags_i[1] = flags_c[1];

      // Alternating round-robin with latency 2.
      add(2'b11, 1'b1, 1'b0, 32'h0,          2'b01, 1'b1, 2'b00, 3'd0, 1'b0, 1'b0);
      add(2'b11, 1'b1, 1'b0, 32'h0,          2'b10, 1'b1, 2'b00, 3'd1, 1'b0, 1'b1);
      add(2'b11, 1'b1, 1'b1, 32'hA000_0000,  2'b01, 1'b1, 2'b01, 3'd2, 1'b0, 1'b0);
      add(2'b11, 1'b1, 1'b1, 32'hA000_0001,  2'b10, 1'b1, 2'b10, 3'd2, 1'b0, 1'b1);
      add(2'b00, 1'b1, 1'b1, 32'hA000_0002,  2'b00, 1'b0, 2'b01, 3'd2, 1'b0, 1'b0);
      add(2'b00, 1'b1, 1'b1, 32'hA000_0003,  2'b00, 1'b0, 2'b10, 3'd1, 1'b0, 1'b0);
      // Zero-latency bypass from requester 1.
      add(2'b10, 1'b1, 1'b1, 32'h3F80_0000,  2'b10, 1'b1, 2'b10, 3'd0, 1'b0, 1'b1);
      add(2'b00, 1'b0, 1'b0, 32'h0,          2'b00, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
      // Fill to MAX_OUTST, then stall, then push+pop while full.
      add(2'b01, 1'b1, 1'b0, 32'h0,          2'b01, 1'b1, 2'b00, 3'd0, 1'b0, 1'b0);
      add(2'b01, 1'b1, 1'b0, 32'h0,          2'b01, 1'b1, 2'b00, 3'd1, 1'b0, 1'b0);
      add(2'b01, 1'b1, 1'b0, 32'h0,          2'b01, 1'b1, 2'b00, 3'd2, 1'b0, 1'b0);
      add(2'b01, 1'b1, 1'b0, 32'h0,          2'b01, 1'b1, 2'b00, 3'd3, 1'b0, 1'b0);
      add(2'b01, 1'b1, 1'b0, 32'h0,          2'b00, 1'b0, 2'b00, 3'd4, 1'b0, 1'b0);
      add(2'b01, 1'b1, 1'b1, 32'hB000_0000,  2'b01, 1'b1, 2'b01, 3'd4, 1'b0, 1'b0);
      add(2'b00, 1'b0, 1'b1, 32'hB000_0001,  2'b00, 1'b0, 2'b01, 3'd4, 1'b0, 1'b0);
      add(2'b00, 1'b0, 1'b1, 32'hB000_0002,  2'b00, 1'b0, 2'b01, 3'd3, 1'b0, 1'b0);
      add(2'b00, 1'b0, 1'b1, 32'hB000_0003,  2'b00, 1'b0, 2'b01, 3'd2, 1'b0, 1'b0);
      add(2'b00, 1'b0, 1'b1, 32'hB000_0004,  2'b00, 1'b0, 2'b01, 3'd1, 1'b0, 1'b0);
      add(2'b00, 1'b0, 1'b0, 32'h0,          2'b00, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
      // Spurious response with nothing in flight; flag is sticky.
      add(2'b00, 1'b0, 1'b1, 32'hC000_0000,  2'b00, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
      add(2'b00, 1'b0, 1'b0, 32'h0,          2'b00, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0);
      add(2'b00, 1'b0, 1'b0, 32'h0,          2'b00, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0);
      // Park rr at 0, then withhold fpu_gnt_i for five cycles.
      add(2'b10, 1'b1, 1'b1, 32'hD000_0000,  2'b10, 1'b1, 2'b10, 3'd0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++)
         add(2'b01, 1'b0, 1'b0, 32'h0,       2'b00, 1'b1, 2'b00, 3'd0, 1'b1, 1'b0);
      add(2'b11, 1'b1, 1'b0, 32'h0,          2'b01, 1'b1, 2'b00, 3'd0, 1'b1, 1'b0);
      add(2'b11, 1'b1, 1'b0, 32'h0,          2'b10, 1'b1, 2'b00, 3'd1, 1'b1, 1'b1);
      add(2'b11, 1'b0, 1'b0, 32'h0,          2'b00, 1'b1, 2'b00, 3'd2, 1'b1, 1'b0);
      add(2'b10, 1'b0, 1'b0, 32'h0,          2'b00, 1'b1, 2'b00, 3'd2, 1'b1, 1'b1);

      // Outputs held at reset values while rst_i is high, even with live inputs.
      rst_i = 1'b1;
      drive(2'b11, 1'b1, 1'b1, 32'h5555_5555);
      #2;
      check("rst gnt",    m_gnt_o,        2'b00);
      check("rst req",    fpu_req_o,      1'b0);
      check("rst rvalid", m_rvalid_o,     2'b00);
      check("rst cnt",    outst_cnt_o,    3'd0);
      check("rst err",    err_spurious_o, 1'b0);
      @(posedge clk_i); @(posedge clk_i); #1;
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      rst_i = 1'b0;

      foreach (vecs[k]) begin
         @(posedge clk_i); #1;
         drive(vecs[k].req, vecs[k].gnt, vecs[k].rv, vecs[k].rdata);
         #3;
         check($sformatf("v%0d gnt", k),    m_gnt_o,        vecs[k].e_gnt);
         check($sformatf("v%0d req", k),    fpu_req_o,      vecs[k].e_req);
         check($sformatf("v%0d rvalid", k), m_rvalid_o,     vecs[k].e_rv);
         check($sformatf("v%0d cnt", k),    outst_cnt_o,    vecs[k].e_cnt);
         check($sformatf("v%0d err", k),    err_spurious_o, vecs[k].e_err);
         check($sformatf("v%0d rdata", k),  m_rdata_o,      vecs[k].rv ? vecs[k].rdata : 32'h0);
         check($sformatf("v%0d rflags", k), m_rflags_o,     vecs[k].rv ? vecs[k].rdata[4:0] : 5'h0);
         check($sformatf("v%0d operands", k), fpu_operands_o, ops_c[vecs[k].e_sel]);
         check($sformatf("v%0d op", k),     fpu_op_o,       op_c[vecs[k].e_sel]);
         check($sformatf("v%0d flags", k),  fpu_flags_o,    flags_c[vecs[k].e_sel]);
      end

      // Third operation in flight, then asynchronous reset in mid-cycle.
      @(posedge clk_i); #1;
      drive(2'b01, 1'b1, 1'b0, 32'h0);
      #3;
      check("pre3 gnt", m_gnt_o, 2'b01);
      check("pre3 cnt", outst_cnt_o, 3'd2);
      @(posedge clk_i); #1;
      drive(2'b11, 1'b1, 1'b1, 32'hE000_0000);
      #1;
      check("inflight cnt",    outst_cnt_o, 3'd3);
      check("inflight rvalid", m_rvalid_o,  2'b01);
      rst_i = 1'b1;
      #1;
      check("async gnt",    m_gnt_o,        2'b00);
      check("async req",    fpu_req_o,      1'b0);
      check("async rvalid", m_rvalid_o,     2'b00);
      check("async cnt",    outst_cnt_o,    3'd0);
      check("async err",    err_spurious_o, 1'b0);
      @(posedge clk_i); #1;
      check("hold cnt", outst_cnt_o, 3'd0);
      drive(2'b00, 1'b0, 1'b1, 32'hF000_0000);
      rst_i = 1'b0;
      #3;
      check("post rvalid", m_rvalid_o,     2'b00);
      check("post cnt",    outst_cnt_o,    3'd0);
      check("post err",    err_spurious_o, 1'b0);
      @(posedge clk_i); #1;
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      #3;
      check("post err set", err_spurious_o, 1'b1);
      check("post rr gnt",  m_gnt_o,        2'b01);
      check("post cnt0",    outst_cnt_o,    3'd0);
      @(posedge clk_i); #1;
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      #3;
      check("post cnt1", outst_cnt_o, 3'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
